// File: rtl/picosoc_mem_wait.sv
// picosoc_mem_wait: on-chip word memory for the picorv32 native bus.
// The memory adds programmable wait states, base-address decode and out-of-range
// error reporting. A request is aborted if the cpu withdraws mem_valid before the
// response is delivered.
module picosoc_mem_wait #(
  parameter int          WORDS       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int         AW        = $clog2(WORDS);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            rng_q, rng_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;

  logic [31:0]     mem_q [WORDS];

  logic            req_rng;
  logic [AW-1:0]   req_idx;
  logic            rd_load;
  logic [AW-1:0]   rd_idx;
  logic            rd_rng;
  logic            wr_en;

  // Decode of the live bus address; the 33-bit compare keeps a window that ends
  // exactly at 4 GiB from wrapping around.
  always_comb begin
    req_rng = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, mem_addr} < LIMIT);
    req_idx = AW'((mem_addr - BASE_ADDR) >> 2);
  end

  // Next-state logic: accept in IDLE, count wait states, then deliver one response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rng_d   = rng_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          idx_d   = req_idx;
          rng_d   = req_rng;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
            rd_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          // Request withdrawn: drop it without a write or a ready pulse.
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          rd_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Array read is registered on the edge entering RESP. With no wait states that
  // edge is the accept edge, so the live address is used instead of the latched one.
  always_comb begin
    rd_idx  = (state_q == S_IDLE) ? req_idx : idx_q;
    rd_rng  = (state_q == S_IDLE) ? req_rng : rng_q;
    rdata_d = rdata_q;
    if (rd_load) rdata_d = rd_rng ? mem_q[rd_idx] : 32'h0;
  end

  // Ready is gated by mem_valid so a request withdrawn during RESP is suppressed.
  always_comb begin
    mem_ready   = (state_q == S_RESP) && mem_valid;
    mem_err     = mem_ready && !rng_q;
    mem_rdata   = rdata_q;
    wr_en       = mem_ready && rng_q && (wstrb_q != 4'h0);
    fetch_cnt_d = fetch_cnt_q + ((mem_ready && mem_instr) ? 32'd1 : 32'd0);
  end

  // Control and datapath registers; all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      rng_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      rdata_q     <= 32'h0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rng_q       <= rng_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Byte-lane write on the RESP edge; the array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // The instruction-fetch count is kept for observation only and drives no output.
  logic unused_fetch;
  assign unused_fetch = ^fetch_cnt_q;

endmodule

// File: tb/tb_picosoc_mem_wait.sv
// Bench for picosoc_mem_wait: three instances with different parameters, a
// table of directed vectors, hand-written abort/reset sequences and random
// traffic checked against a word-level model of the memory.
module tb_picosoc_mem_wait;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid [3];
  logic        instr [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        err   [3];

  int     errors = 0;
  int     checks = 0;

  int     W_     [3] = '{0, 3, 4};
  longint BASE_  [3] = '{64'h0, 64'h0, 64'h1000};
  int     WORDS_ [3] = '{256, 256, 32};

  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  picosoc_mem_wait #(.WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0]));

  picosoc_mem_wait #(.WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1]));

  picosoc_mem_wait #(.WORDS(32), .BASE_ADDR(32'h1000), .WAIT_CYCLES(4)) u2 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[2]), .mem_instr(instr[2]),
    .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
    .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_err(err[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input int k, input logic [31:0] a);
    longint la = longint'(a);
    return (la >= BASE_[k]) && (la < BASE_[k] + longint'(WORDS_[k]) * 4);
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    longint la = longint'(a);
    return k * 65536 + int'((la - BASE_[k]) >> 2);
  endfunction

  // Value a read of address a must return: stored word if in range, else zero.
  function automatic logic [31:0] model_rd(input int k, input logic [31:0] a);
    if (!in_rng(k, a)) return 32'h0;
    if (!mdl.exists(key(k, a))) return 32'h0;
    return mdl[key(k, a)];
  endfunction

  function automatic void model_wr(input int k, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] w;
    if (!in_rng(k, a) || ws == 4'h0) return;
    w = model_rd(k, a);
    for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
    mdl[key(k, a)] = w;
  endfunction

  // One complete bus transaction on instance k; checks latency, single-cycle pulse
  // and that rdata holds after the pulse, then commits the write to the model.
  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input bit ins,
                      output logic [31:0] rd, output logic er);
    int n;
    bit got;
    @(posedge clk); #1;
    valid[k] = 1'b1; addr[k] = a; wdata[k] = wd; wstrb[k] = ws; instr[k] = ins;
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready[k]) got = 1;
    end
    chk($sformatf("latency[%0d]", k), n, W_[k] + 1);
    rd = rdata[k];
    er = err[k];
    if (got) begin
      @(posedge clk); #1;
      chk($sformatf("pulse[%0d]", k), {31'h0, ready[k]}, 32'h0);
      chk($sformatf("hold[%0d]", k), rdata[k], rd);
      model_wr(k, a, wd, ws);
    end
    valid[k] = 1'b0; wstrb[k] = 4'h0;
  endtask

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    bit          crd;
    logic [31:0] erd;
    logic        eer;
  } vec_t;

  initial begin
    vec_t        tbl [$];
    logic [31:0] rd, exp_rd;
    logic        er;
    bit          seen;

    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 0; instr[k] = 0; addr[k] = 0; wdata[k] = 0; wstrb[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready[%0d]", k), {31'h0, ready[k]}, 32'h0);
      chk($sformatf("rst_err[%0d]", k), {31'h0, err[k]}, 32'h0);
      chk($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
    end
    resetn = 1'b1;

    // Preload every word of every instance so the model knows all contents.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < WORDS_[k]; i++) begin
        xact(k, 32'(BASE_[k] + longint'(i) * 4), $urandom, 4'hF, 1'b0, rd, er);
        chk("preload_err", {31'h0, er}, 32'h0);
      end

    // Directed vectors with hand-computed expectations.
    tbl.push_back('{0, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 32'h10,   32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 32'h20,   32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 32'h20,   32'hAABBCCDD, 4'h5, 1'b1, 32'h11223344, 1'b0});
    tbl.push_back('{0, 32'h20,   32'h0,        4'h0, 1'b1, 32'h11BB33DD, 1'b0});
    tbl.push_back('{0, 32'h23,   32'h0,        4'h0, 1'b1, 32'h11BB33DD, 1'b0});
    tbl.push_back('{0, 32'h3FC,  32'h0BADCAFE, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{0, 32'h3FC,  32'h0,        4'h0, 1'b1, 32'h0BADCAFE, 1'b0});
    tbl.push_back('{0, 32'h400,  32'h12345678, 4'hF, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{1, 32'h0,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1, 32'h0,    32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0});
    tbl.push_back('{2, 32'h1080, 32'h55AA55AA, 4'hF, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{2, 32'h0FFC, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{2, 32'h107C, 32'h76543210, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{2, 32'h107C, 32'h0,        4'h0, 1'b1, 32'h76543210, 1'b0});
    foreach (tbl[i]) begin
      xact(tbl[i].k, tbl[i].a, tbl[i].wd, tbl[i].ws, 1'b0, rd, er);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].eer});
      if (tbl[i].crd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
    end

    // Out-of-range writes must leave the arrays untouched.
    for (int i = 0; i < 32; i++) begin
      exp_rd = model_rd(2, 32'h1000 + 32'(i * 4));
      xact(2, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, 1'b0, rd, er);
      chk("oor_sweep", rd, exp_rd);
    end
    exp_rd = model_rd(0, 32'h0);
    xact(0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er);
    chk("oor_word0", rd, exp_rd);

    // Abort in the 2nd wait cycle (4 wait states).
    @(posedge clk); #1;
    valid[2] = 1'b1; addr[2] = 32'h1040; wdata[2] = 32'hFFFFFFFF; wstrb[2] = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    valid[2] = 1'b0; wstrb[2] = 4'h0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (ready[2]) seen = 1; end
    chk("abort_wait2_ready", {31'h0, seen}, 32'h0);
    exp_rd = model_rd(2, 32'h1040);
    xact(2, 32'h1040, 32'h0, 4'h0, 1'b0, rd, er);
    chk("abort_wait2_nowrite", rd, exp_rd);

    // Abort in the last wait cycle (3 wait states).
    @(posedge clk); #1;
    valid[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h5A5A5A5A; wstrb[1] = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    valid[1] = 1'b0; wstrb[1] = 4'h0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready[1]) seen = 1; end
    chk("abort_last_ready", {31'h0, seen}, 32'h0);
    exp_rd = model_rd(1, 32'h40);
    xact(1, 32'h40, 32'h0, 4'h0, 1'b0, rd, er);
    chk("abort_last_nowrite", rd, exp_rd);

    // Reset during WAIT: outputs clear at once, memory survives, write is lost.
    xact(1, 32'h0, 32'h0, 4'h0, 1'b0, rd, er);
    chk("pre_reset_rdata", rd, 32'hCAFEF00D);
    @(posedge clk); #1;
    valid[1] = 1'b1; addr[1] = 32'h44; wdata[1] = 32'hA5A5A5A5; wstrb[1] = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ready[1]}, 32'h0);
    chk("midrst_err", {31'h0, err[1]}, 32'h0);
    chk("midrst_rdata", rdata[1], 32'h0);
    valid[1] = 1'b0; wstrb[1] = 4'h0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_rd = model_rd(1, 32'h44);
    xact(1, 32'h44, 32'h0, 4'h0, 1'b0, rd, er);
    chk("midrst_nowrite", rd, exp_rd);
    xact(1, 32'h0, 32'h0, 4'h0, 1'b0, rd, er);
    chk("midrst_preserved", rd, 32'hCAFEF00D);

    // Random traffic against the model, including out-of-range addresses.
    for (int i = 0; i < 200; i++) begin
      int          k;
      logic [31:0] a, wd;
      logic [3:0]  ws;
      logic        exp_er;
      k  = $urandom_range(0, 2);
      a  = (k < 2) ? 32'($urandom_range(0, 32'h4FF)) : 32'($urandom_range(32'h0F00, 32'h11FF));
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      exp_rd = model_rd(k, a);
      exp_er = !in_rng(k, a);
      xact(k, a, wd, ws, 1'($urandom_range(0, 1)), rd, er);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), {31'h0, er}, {31'h0, exp_er});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
